// File: rtl/input_arbiter_pkg.sv
// Local types and helpers for the input arbiter.
package input_arbiter_pkg;
  typedef enum logic {FL_IDLE, FL_WAIT} fl_state_e;

  function automatic int unsigned rr_next(int unsigned p, int unsigned n);
    return (p + 1 >= n) ? 0 : p + 1;
  endfunction
endpackage

// File: rtl/mem_pkg.sv
// Packet-memory geometry shared by writers and the memory itself.
package mem_pkg;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned BLOCK_BITS = 32;
endpackage

// File: rtl/switch_pkg.sv
// Switch-wide constants shared by the port datapath stages.
package switch_pkg;
  localparam int unsigned NUM_PORTS = 4;
  typedef logic [$clog2(NUM_PORTS)-1:0] port_idx_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx,
  output logic            valid
);

  int unsigned     c;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    c     = 0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      c    = (32'(ptr) + i) % N;
      cand = IdxW'(c);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_arbiter.sv
// Round-robin arbitration of port memory writes and free-list allocations.
// Optional INPUT_ARB_PERF_EN adds saturating per-port memory grant counters.
module input_arbiter
  import input_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = switch_pkg::NUM_PORTS,
  parameter int unsigned ADDR_W     = mem_pkg::ADDR_W,
  parameter int unsigned BLOCK_BITS = mem_pkg::BLOCK_BITS
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_PORTS-1:0]                  port_mem_we_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]      port_mem_addr_i,
  input  logic [NUM_PORTS-1:0][BLOCK_BITS-1:0]  port_mem_wdata_i,
  output logic [NUM_PORTS-1:0]                  port_mem_gnt_o,
  input  logic [NUM_PORTS-1:0]                  port_fl_req_i,
  output logic [NUM_PORTS-1:0]                  port_fl_gnt_o,
  output logic [ADDR_W-1:0]                     port_fl_block_idx_o,
  input  logic                                  mem_ready_i,
  output logic                                  mem_we_o,
  output logic [ADDR_W-1:0]                     mem_addr_o,
  output logic [BLOCK_BITS-1:0]                 mem_wdata_o,
  output logic                                  fl_alloc_req_o,
  input  logic                                  fl_alloc_gnt_i,
  input  logic [ADDR_W-1:0]                     fl_alloc_block_idx_i
`ifdef INPUT_ARB_PERF_EN
  ,
  output logic [NUM_PORTS-1:0][15:0]            port_mem_grant_cnt_o
`endif
);

  localparam int unsigned IdxW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [IdxW-1:0]      mem_ptr, mem_win;
  logic [NUM_PORTS-1:0] mem_rr_gnt;
  logic                 mem_any, mem_fire;

  logic [IdxW-1:0]      fl_ptr, fl_win, fl_owner;
  logic [NUM_PORTS-1:0] fl_rr_gnt;
  logic                 fl_any, fl_fire;
  fl_state_e            fl_state;

  rr_arbiter #(.N(NUM_PORTS)) u_mem_rr (
    .req   (port_mem_we_i),
    .ptr   (mem_ptr),
    .gnt   (mem_rr_gnt),
    .idx   (mem_win),
    .valid (mem_any)
  );

  rr_arbiter #(.N(NUM_PORTS)) u_fl_rr (
    .req   (port_fl_req_i),
    .ptr   (fl_ptr),
    .gnt   (fl_rr_gnt),
    .idx   (fl_win),
    .valid (fl_any)
  );

  // Grants are suppressed while reset is asserted so nothing leaks in the reset cycle.
  assign mem_fire       = rst_n && mem_ready_i && mem_any;
  assign port_mem_gnt_o = mem_fire ? mem_rr_gnt : '0;

  assign fl_alloc_req_o      = rst_n && (fl_state == FL_WAIT) && port_fl_req_i[fl_owner];
  assign fl_fire             = fl_alloc_req_o && fl_alloc_gnt_i;
  assign port_fl_block_idx_o = fl_alloc_block_idx_i;

  always_comb begin
    port_fl_gnt_o = '0;
    if (fl_fire) port_fl_gnt_o[fl_owner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_ptr     <= '0;
    end else if (mem_fire) begin
      mem_we_o    <= 1'b1;
      mem_addr_o  <= port_mem_addr_i[mem_win];
      mem_wdata_o <= port_mem_wdata_i[mem_win];
      mem_ptr     <= IdxW'(rr_next(32'(mem_win), NUM_PORTS));
    end else begin
      mem_we_o <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fl_state <= FL_IDLE;
      fl_owner <= '0;
      fl_ptr   <= '0;
    end else begin
      unique case (fl_state)
        FL_IDLE: begin
          if (fl_any) begin
            fl_owner <= fl_win;
            fl_state <= FL_WAIT;
          end
        end
        FL_WAIT: begin
          if (fl_fire) begin
            fl_ptr   <= IdxW'(rr_next(32'(fl_owner), NUM_PORTS));
            fl_state <= FL_IDLE;
          end else if (!port_fl_req_i[fl_owner]) begin
            // Owner withdrew before the free list answered: abort, pointer unchanged.
            fl_state <= FL_IDLE;
          end
        end
        default: fl_state <= FL_IDLE;
      endcase
    end
  end

`ifdef INPUT_ARB_PERF_EN
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!rst_n) begin
        port_mem_grant_cnt_o[i] <= '0;
      end else if (port_mem_gnt_o[i] && port_mem_grant_cnt_o[i] != 16'hFFFF) begin
        port_mem_grant_cnt_o[i] <= port_mem_grant_cnt_o[i] + 16'd1;
      end
    end
  end
`endif

  logic unused_fl_rr_gnt;
  assign unused_fl_rr_gnt = ^fl_rr_gnt;

endmodule

// File: tb/tb_input_arbiter.sv
// Directed self-checking bench for input_arbiter.
module tb_input_arbiter;
  localparam int unsigned NP = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned BW = 32;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NP-1:0]          port_mem_we;
  logic [NP-1:0][AW-1:0]  port_mem_addr;
  logic [NP-1:0][BW-1:0]  port_mem_wdata;
  logic [NP-1:0]          port_mem_gnt;
  logic [NP-1:0]          port_fl_req;
  logic [NP-1:0]          port_fl_gnt;
  logic [AW-1:0]          port_fl_block_idx;
  logic                   mem_ready;
  logic                   mem_we;
  logic [AW-1:0]          mem_addr;
  logic [BW-1:0]          mem_wdata;
  logic                   fl_alloc_req;
  logic                   fl_alloc_gnt;
  logic [AW-1:0]          fl_alloc_block_idx;
`ifdef INPUT_ARB_PERF_EN
  logic [NP-1:0][15:0]    grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  input_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .BLOCK_BITS(BW)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .port_mem_we_i        (port_mem_we),
    .port_mem_addr_i      (port_mem_addr),
    .port_mem_wdata_i     (port_mem_wdata),
    .port_mem_gnt_o       (port_mem_gnt),
    .port_fl_req_i        (port_fl_req),
    .port_fl_gnt_o        (port_fl_gnt),
    .port_fl_block_idx_o  (port_fl_block_idx),
    .mem_ready_i          (mem_ready),
    .mem_we_o             (mem_we),
    .mem_addr_o           (mem_addr),
    .mem_wdata_o          (mem_wdata),
    .fl_alloc_req_o       (fl_alloc_req),
    .fl_alloc_gnt_i       (fl_alloc_gnt),
    .fl_alloc_block_idx_i (fl_alloc_block_idx)
`ifdef INPUT_ARB_PERF_EN
    ,
    .port_mem_grant_cnt_o (grant_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n              = 1'b0;
    port_mem_we        = '0;
    port_fl_req        = '0;
    mem_ready          = 1'b0;
    fl_alloc_gnt       = 1'b0;
    fl_alloc_block_idx = '0;
    for (int i = 0; i < NP; i++) begin
      port_mem_addr[i]  = AW'(10 + i);
      port_mem_wdata[i] = BW'(32'hA000 + i);
    end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_mem_we", 64'(mem_we), 64'h0);
    check("rst_mem_addr", 64'(mem_addr), 64'h0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'h0);
    check("rst_fl_req", 64'(fl_alloc_req), 64'h0);
    check("rst_mem_gnt", 64'(port_mem_gnt), 64'h0);
    check("rst_fl_gnt", 64'(port_fl_gnt), 64'h0);

    // Fairness: all four ports request continuously.
    port_mem_we = 4'hF;
    mem_ready   = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      check("fair_gnt", 64'(port_mem_gnt), 64'(1 << (k % 4)));
      tick();
      check("fair_we", 64'(mem_we), 64'h1);
      check("fair_addr", 64'(mem_addr), 64'(10 + (k % 4)));
      check("fair_wdata", 64'(mem_wdata), 64'(32'hA000 + (k % 4)));
      #1;
    end
    port_mem_we = '0;
    #1;
    check("idle_gnt", 64'(port_mem_gnt), 64'h0);
    tick();
    check("idle_we", 64'(mem_we), 64'h0);

    // Backpressure: port 2 waits three not-ready cycles.
    port_mem_we      = 4'b0100;
    port_mem_addr[2] = 8'd5;
    mem_ready        = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_gnt", 64'(port_mem_gnt), 64'h0);
      tick();
      check("bp_we", 64'(mem_we), 64'h0);
    end
    mem_ready = 1'b1;
    #1;
    check("bp_rel_gnt", 64'(port_mem_gnt), 64'h4);
    tick();
    port_mem_we = '0;
    check("bp_rel_we", 64'(mem_we), 64'h1);
    check("bp_rel_addr", 64'(mem_addr), 64'h5);
    port_mem_addr[2] = AW'(12);

    // Allocation: ports 1 and 3 request.
    port_fl_req = 4'b1010;
    #1;
    check("al_idle_req", 64'(fl_alloc_req), 64'h0);
    check("al_idle_gnt", 64'(port_fl_gnt), 64'h0);
    tick();
    check("al_wait_req", 64'(fl_alloc_req), 64'h1);
    check("al_wait_gnt", 64'(port_fl_gnt), 64'h0);
    fl_alloc_gnt       = 1'b1;
    fl_alloc_block_idx = 8'd7;
    #1;
    check("al_gnt1", 64'(port_fl_gnt), 64'h2);
    check("al_idx7", 64'(port_fl_block_idx), 64'h7);
    tick();
    port_fl_req  = 4'b1000;
    fl_alloc_gnt = 1'b0;
    #1;
    check("al_gap_req", 64'(fl_alloc_req), 64'h0);
    check("al_gap_gnt", 64'(port_fl_gnt), 64'h0);
    tick();
    check("al_wait3_req", 64'(fl_alloc_req), 64'h1);
    fl_alloc_gnt       = 1'b1;
    fl_alloc_block_idx = 8'd9;
    #1;
    check("al_gnt3", 64'(port_fl_gnt), 64'h8);
    check("al_idx9", 64'(port_fl_block_idx), 64'h9);
    tick();
    port_fl_req  = '0;
    fl_alloc_gnt = 1'b0;
    #1;

    // Free list empty: port 0 waits ten cycles, then one pulse.
    port_fl_req = 4'b0001;
    tick();
    for (int k = 0; k < 10; k++) begin
      check("empty_req", 64'(fl_alloc_req), 64'h1);
      check("empty_gnt", 64'(port_fl_gnt), 64'h0);
      tick();
    end
    fl_alloc_gnt = 1'b1;
    #1;
    check("empty_rel_gnt", 64'(port_fl_gnt), 64'h1);
    tick();
    port_fl_req  = '0;
    fl_alloc_gnt = 1'b0;
    #1;
    check("empty_done_req", 64'(fl_alloc_req), 64'h0);
    check("empty_done_gnt", 64'(port_fl_gnt), 64'h0);

    // Reset while the free-list FSM waits on port 2.
    port_fl_req = 4'b0100;
    port_mem_we = 4'b0010;
    #1;
    check("rw_mem_gnt", 64'(port_mem_gnt), 64'h2);
    tick();
    port_mem_we = '0;
    check("rw_mem_we", 64'(mem_we), 64'h1);
    check("rw_wait_req", 64'(fl_alloc_req), 64'h1);
    rst_n        = 1'b0;
    fl_alloc_gnt = 1'b1;
    port_mem_we  = 4'hF;
    #1;
    check("rw_inrst_req", 64'(fl_alloc_req), 64'h0);
    check("rw_inrst_flg", 64'(port_fl_gnt), 64'h0);
    check("rw_inrst_mg", 64'(port_mem_gnt), 64'h0);
    tick();
    rst_n        = 1'b1;
    fl_alloc_gnt = 1'b0;
    port_fl_req  = 4'hF;
    #1;
    check("rw_post_we", 64'(mem_we), 64'h0);
    check("rw_post_req", 64'(fl_alloc_req), 64'h0);
    check("rw_post_mg", 64'(port_mem_gnt), 64'h1);
    tick();
    port_mem_we = '0;
    check("rw_post_addr", 64'(mem_addr), 64'(10));
    fl_alloc_gnt       = 1'b1;
    fl_alloc_block_idx = 8'd3;
    #1;
    check("rw_post_flg", 64'(port_fl_gnt), 64'h1);
    tick();
    port_fl_req  = '0;
    fl_alloc_gnt = 1'b0;

    // Concurrency: ports 0 and 2 hit both arbiters from a fresh reset.
    rst_n = 1'b0;
    tick();
    tick();
    rst_n       = 1'b1;
    port_mem_we = 4'b0101;
    port_fl_req = 4'b0101;
    #1;
    check("cc_mem_gnt", 64'(port_mem_gnt), 64'h1);
    tick();
    check("cc_mem_we", 64'(mem_we), 64'h1);
    check("cc_mem_addr", 64'(mem_addr), 64'(10));
`ifdef INPUT_ARB_PERF_EN
    check("cc_cnt", 64'(grant_cnt), 64'h0000_0000_0000_0001);
`endif
    fl_alloc_gnt = 1'b1;
    #1;
    check("cc_fl_gnt", 64'(port_fl_gnt), 64'h1);
    check("cc_mem_gnt2", 64'(port_mem_gnt), 64'h4);
    tick();
    port_mem_we  = '0;
    port_fl_req  = '0;
    fl_alloc_gnt = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
